// File: rtl/rca_serial_32bit_pkg.sv
// Shared definitions for the chunked ripple-carry adder: FSM state encodings,
// default geometry and the index-width helper.
package rca_serial_32bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_CHUNK_W = 8;

    // A single-chunk build still needs a 1-bit index register.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK_W-bit ripple adder slice; also exports the carry into
// its MSB so the top can derive signed overflow on the final chunk.
module rca_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/rca_serial_32bit.sv
// Multi-cycle chunked ripple-carry adder with valid/ready on both sides.
// Optional signed-overflow output is enabled by defining RCA_OVF_FLAG_EN.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for operands
// BUSY    | adding one CHUNK_W slice per cycle, carry held in creg_q
// DONE    | out_valid=1, result held until out_ready
module rca_serial_32bit
    import rca_serial_32bit_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CHUNK_W = DEF_CHUNK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef RCA_OVF_FLAG_EN
    output logic             carry,
    output logic             overflow
`else
    output logic             carry
`endif
);

    localparam int                NCHUNK   = WIDTH / CHUNK_W;
    localparam int                IDX_W    = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0]  CHUNK_MASK = WIDTH'({CHUNK_W{1'b1}});

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               creg_q, creg_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    logic [31:0]        chunk_sh;
    logic [CHUNK_W-1:0] chunk_a, chunk_b, chunk_sum;
    logic               chunk_cout, chunk_c_msb;

    // Slice selection by shifting keeps the index arithmetic width-agnostic.
    assign chunk_sh = 32'(idx_q) * 32'(CHUNK_W);
    assign chunk_a  = CHUNK_W'(a_q >> chunk_sh);
    assign chunk_b  = CHUNK_W'(b_q >> chunk_sh);

    rca_chunk #(
        .W (CHUNK_W)
    ) u_chunk (
        .a     (chunk_a),
        .b     (chunk_b),
        .cin   (creg_q),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_c_msb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        creg_d  = creg_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    creg_d  = carry_in;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                sum_d  = (sum_q & ~(CHUNK_MASK << chunk_sh))
                       | (WIDTH'(chunk_sum) << chunk_sh);
                creg_d = chunk_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    carry_d = chunk_cout;
                    ovf_d   = chunk_c_msb ^ chunk_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            creg_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            creg_q  <= creg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;

`ifdef RCA_OVF_FLAG_EN
    assign overflow = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q ^ chunk_c_msb;
`endif

endmodule

// File: tb/tb_rca_serial_32bit.sv
// Directed-vector bench for rca_serial_32bit; overflow checks are compiled in
// only when RCA_OVF_FLAG_EN is defined.
module tb_rca_serial_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        carry;
`ifdef RCA_OVF_FLAG_EN
    logic        overflow;
`endif

    int checks = 0;
    int errors = 0;

    rca_serial_32bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef RCA_OVF_FLAG_EN
        .carry     (carry),
        .overflow  (overflow)
`else
        .carry     (carry)
`endif
    );

    always #5 clk = ~clk;

    // Issue one operation, wait (bounded) for the result, capture it, drain it.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                          output logic [31:0] rs, output logic rc, output logic ro,
                          output int lat);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_op_in_ready: got %b expected 1", in_ready);
        end
        a = ta; b = tb_v; carry_in = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        rs = sum;
        rc = carry;
`ifdef RCA_OVF_FLAG_EN
        ro = overflow;
`else
        ro = 1'b0;
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry); end
`ifdef RCA_OVF_FLAG_EN
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`endif
    endtask

    task automatic test_add();
        logic [31:0] va [6] = '{32'h12345678, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005, 32'h80000000, 32'h00FF00FF};
        logic [31:0] vb [6] = '{32'h9ABCDEF0, 32'h00000001, 32'h00000001, 32'hFFFFFFFC, 32'h80000000, 32'h00010001};
        logic        vc [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] es [6] = '{32'hACF13569, 32'h00000000, 32'h80000000, 32'h00000002, 32'h00000000, 32'h01000100};
        logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] rs;
        logic        rc, ro;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vc[i], rs, rc, ro, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL add%0d_latency: got %0d expected 4", i, lat); end
            checks++; if (rs !== es[i]) begin errors++; $display("FAIL add%0d_sum: got %h expected %h", i, rs, es[i]); end
            checks++; if (rc !== ec[i]) begin errors++; $display("FAIL add%0d_carry: got %b expected %b", i, rc, ec[i]); end
`ifdef RCA_OVF_FLAG_EN
            checks++; if (ro !== eo[i]) begin errors++; $display("FAIL add%0d_overflow: got %b expected %b", i, ro, eo[i]); end
`else
            if (ro !== 1'b0 && eo[i] === 1'b0) $display("note: unexpected ovf capture");
`endif
        end
    endtask

    task automatic test_hold();
        int lat;
        @(negedge clk);
        a = 32'h00001111; b = 32'h00002222; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL hold_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_out_valid: got %b expected 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready: got %b expected 0", i, in_ready); end
            checks++; if (sum !== 32'h00003333) begin errors++; $display("FAIL hold%0d_sum: got %h expected 00003333", i, sum); end
            checks++; if (carry !== 1'b0) begin errors++; $display("FAIL hold%0d_carry: got %b expected 0", i, carry); end
            a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; carry_in = 1'b1; in_valid = (i % 2 == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain_out_valid: got %b expected 0", out_valid); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_drain_in_ready: got %b expected 1", in_ready); end
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rs;
        logic        rc, ro;
        int          lat;
        @(negedge clk);
        a = 32'h01010101; b = 32'h02020202; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstbusy_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstbusy_in_ready: got %b expected 1", in_ready); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL rstbusy_sum: got %h expected 00000000", sum); end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstbusy_after_out_valid: got %b expected 0", out_valid); end
        end
        run_op(32'h11111111, 32'h22222222, 1'b1, rs, rc, ro, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rstbusy_next_latency: got %0d expected 4", lat); end
        checks++; if (rs !== 32'h33333334) begin errors++; $display("FAIL rstbusy_next_sum: got %h expected 33333334", rs); end
        checks++; if (rc !== 1'b0) begin errors++; $display("FAIL rstbusy_next_carry: got %b expected 0", rc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rs;
        logic        rc, ro;
        int          lat;
        run_op(32'hF0000000, 32'h20000000, 1'b0, rs, rc, ro, lat);
        checks++; if (rs !== 32'h10000000) begin errors++; $display("FAIL b2b0_sum: got %h expected 10000000", rs); end
        checks++; if (rc !== 1'b1) begin errors++; $display("FAIL b2b0_carry: got %b expected 1", rc); end
        run_op(32'h000000FF, 32'h000000FF, 1'b1, rs, rc, ro, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b1_latency: got %0d expected 4", lat); end
        checks++; if (rs !== 32'h000001FF) begin errors++; $display("FAIL b2b1_sum: got %h expected 000001FF", rs); end
        checks++; if (rc !== 1'b0) begin errors++; $display("FAIL b2b1_carry: got %b expected 0", rc); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; carry_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_add();
        test_hold();
        test_reset_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
